// File: rtl/axi_dac_reader.sv
// Streams ping/pong memory buffers over AXI4 reads into a FWFT playback FIFO
// feeding a DAC-side valid/ready stream; loops until go falls.
module axi_dac_reader #(
    parameter int unsigned BURST_LEN  = 128,
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        go,
    input  logic [31:0] rd_addr_0,
    input  logic [31:0] rd_addr_1,
    input  logic [31:0] data_len,
    input  logic        int_clr,
    output logic        irq,
    output logic        done,
    output logic        rd_buf_index,
    output logic [31:0] read_count,
    output logic        fifo_underflow,
    output logic        rd_error,
    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [63:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic [63:0] dac_data,
    output logic        dac_valid,
    input  logic        dac_ready
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [8:0]  BURST_CAP = BURST_LEN[8:0];

    typedef enum logic [3:0] {
        IDLE, START, BURST_BEGIN, BURST_WAIT, AR, DATA, BURST_END, DONE, DRAIN
    } state_t;

    state_t      state, state_next;
    logic [1:0]  rst_sync;
    logic [31:0] addr;
    logic [28:0] remain;
    logic [8:0]  burst;
    logic        idx;
    logic [63:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, free;
    logic        empty, full, push, pop, clr, delivered;
    logic        enter_done, err_set, uf_cond;
    logic        unused_bits;

    assign unused_bits = ^{rd_addr_0[9:0], rd_addr_1[9:0], data_len[2:0]};

    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = burst[7:0] - 8'd1;
    assign M_AXI_ARSIZE  = 3'b011;
    assign M_AXI_ARBURST = 2'b01;

    // Deassertion of ARESETN only takes effect after two ACLK edges.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next    = state;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        unique case (state)
            IDLE:        if (go && rst_sync[1]) state_next = START;
            START: begin
                if (!go)                         state_next = IDLE;
                else if (data_len[31:3] == '0)   state_next = DONE;
                else                             state_next = BURST_BEGIN;
            end
            BURST_BEGIN: state_next = go ? BURST_WAIT : IDLE;
            BURST_WAIT: begin
                if (!go)                              state_next = IDLE;
                else if (32'(free) >= 32'(burst))     state_next = AR;
            end
            AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_next = go ? DATA : DRAIN;
            end
            DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && M_AXI_RLAST) state_next = go ? BURST_END : IDLE;
                else if (!go)                    state_next = DRAIN;
            end
            BURST_END: begin
                if (!go)                state_next = IDLE;
                else if (remain != '0)  state_next = BURST_BEGIN;
                else                    state_next = DONE;
            end
            DONE:  state_next = go ? START : IDLE;
            DRAIN: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && M_AXI_RLAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr       <= '0;
            remain     <= '0;
            burst      <= '0;
            idx        <= 1'b0;
            read_count <= '0;
        end else begin
            unique case (state)
                START: begin
                    remain <= data_len[31:3];
                    addr   <= idx ? {rd_addr_1[31:10], 10'b0} : {rd_addr_0[31:10], 10'b0};
                end
                BURST_BEGIN: burst <= (remain < 29'(BURST_LEN)) ? remain[8:0] : BURST_CAP;
                DATA:        if (M_AXI_RVALID && M_AXI_RLAST) remain <= remain - {20'b0, burst};
                BURST_END:   addr <= addr + {20'b0, burst, 3'b000};
                DONE: begin
                    idx        <= ~idx;
                    read_count <= read_count + 32'd1;
                end
                default: ;
            endcase
            if (!go) begin
                idx        <= 1'b0;
                read_count <= '0;
            end
        end
    end

    // Playback FIFO: pointers carry one extra wrap bit; dropping go flushes it.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr == (rd_ptr ^ DEPTH_W));
    assign free      = DEPTH_W - (wr_ptr - rd_ptr);
    assign push      = (state == DATA) && M_AXI_RVALID && go && !full;
    assign dac_valid = !empty && go;
    assign pop       = dac_valid && dac_ready;
    assign dac_data  = dac_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= M_AXI_RDATA;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            delivered <= 1'b0;
        end else if (!go) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            delivered <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                delivered <= 1'b1;
            end
        end
    end

    assign clr        = int_clr || !go;
    assign enter_done = (state_next == DONE);
    assign err_set    = ((state == DATA) || (state == DRAIN)) && M_AXI_RVALID && (M_AXI_RRESP != 2'b00);
    assign uf_cond    = go && dac_ready && empty && delivered;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq            <= 1'b0;
            done           <= 1'b0;
            rd_buf_index   <= 1'b0;
            fifo_underflow <= 1'b0;
            rd_error       <= 1'b0;
        end else begin
            if (enter_done) rd_buf_index <= idx;
            if (clr) begin
                irq            <= 1'b0;
                done           <= 1'b0;
                fifo_underflow <= 1'b0;
                rd_error       <= 1'b0;
            end else begin
                done           <= done | enter_done;
                rd_error       <= rd_error | err_set;
                fifo_underflow <= fifo_underflow | uf_cond;
                irq            <= irq | enter_done | (err_set & ~rd_error) | (uf_cond & ~fifo_underflow);
            end
        end
    end

endmodule

// File: doc/axi_dac_reader.md
AXI_DAC_READER -- requirements
Module: axi_dac_reader

Interface
Parameters (name, default, meaning):
REQ-001 BURST_LEN, 128, maximum beats per AXI read burst (1..256).
REQ-002 FIFO_DEPTH, 1024, playback FIFO depth in 64-bit words (power of two, >= 2*BURST_LEN).

Ports (name, direction, width, meaning):
REQ-003 ACLK  in  1  single clock for all logic.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 go  in  1  run enable; low means stop, flush and hold idle.
REQ-006 rd_addr_0, rd_addr_1  in  32 each  ping/pong buffer byte addresses; bits [9:0] are ignored and treated as zero.
REQ-007 data_len  in  32  buffer length in bytes; bits [2:0] are ignored.
REQ-008 int_clr  in  1  one-cycle pulse that clears irq, done and the sticky error flags.
REQ-009 irq  out  1  interrupt.
REQ-010 done, rd_buf_index  out  1 each  buffer-complete flag; index of the last completed buffer.
REQ-011 read_count  out  32  number of completed buffers since go rose.
REQ-012 fifo_underflow, rd_error  out  1 each  sticky error flags.
REQ-013 M_AXI_ARADDR  out  32; M_AXI_ARLEN  out  8; M_AXI_ARSIZE  out  3; M_AXI_ARBURST  out  2; M_AXI_ARVALID  out  1; M_AXI_ARREADY  in  1.
REQ-014 M_AXI_RDATA  in  64; M_AXI_RRESP  in  2; M_AXI_RLAST  in  1; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1.
REQ-015 dac_data  out  64; dac_valid  out  1; dac_ready  in  1 (DAC-side stream, on ACLK).

Function
REQ-016 ARSIZE is held at 3'b011 and ARBURST at 2'b01; the block issues reads only and has at most one burst outstanding.
REQ-017 FSM states are IDLE, START, BURST_BEGIN, BURST_WAIT, AR, DATA, BURST_END, DONE, and DRAIN.
- IDLE -> START when go=1.
- START: latch remain = data_len[31:3]; latch addr from rd_addr_0 if the internal index is 0, otherwise from rd_addr_1. If remain = 0, go to DONE; otherwise go to BURST_BEGIN.
- BURST_BEGIN: burst = min(remain, BURST_LEN).
- BURST_WAIT: wait until free FIFO space >= burst.
- AR: assert ARVALID with ARADDR = addr and ARLEN = burst-1. Hold both stable until ARREADY; on ARREADY go to DATA.
- DATA: RREADY = 1. Each RVALID beat writes RDATA into the FIFO. On the beat with RLAST, remain -= burst and go to BURST_END.
- BURST_END: addr += burst*8 (32-bit wrap). Go to BURST_BEGIN if remain != 0, otherwise go to DONE.
- DONE: toggle the internal index, read_count += 1, then go to START. Playback loops over ping/pong buffers continuously.
REQ-018 RLAST is authoritative for ending a burst. A beat count mismatch against burst does not stall the FSM.
REQ-019 Any beat with RRESP != 2'b00 sets rd_error. Its data is still written to the FIFO.
REQ-020 dac_valid = FIFO not empty. A FIFO word is popped when dac_valid && dac_ready. dac_data is first-word-fall-through.
REQ-021 fifo_underflow sets when dac_ready=1 and the FIFO is empty while go=1, but only after the first word of the current run has been delivered.
REQ-022 On entering DONE, done <= 1 and rd_buf_index <= the internal index of the buffer just completed.
REQ-023 irq sets on entry to DONE or on a rising edge of fifo_underflow or rd_error.
REQ-024 irq, done, fifo_underflow and rd_error clear on int_clr or go=0. When clear and set occur in the same cycle, clear wins.
REQ-025 go falls during AR:
- Keep ARVALID and ARADDR stable until ARREADY, then enter DRAIN.
REQ-026 go falls during DATA:
- Enter DRAIN.
- In DRAIN, hold RREADY=1 and discard beats (no FIFO write) until RLAST, then go to IDLE.
REQ-027 go falls in any other state:
- Go to IDLE next cycle.
REQ-028 While go=0 (all states, including DRAIN):
- The FIFO is flushed (empty, dac_valid=0).
- The internal index and read_count return to 0.
REQ-029 A simultaneous FIFO push and pop in the same cycle is legal, and the occupancy is unchanged.
REQ-030 The FIFO is never written while full. REQ-017 BURST_WAIT guarantees this by construction.

Reset
REQ-031 ARESETN low asynchronously forces all of the following:
- FSM to IDLE.
- ARVALID=0, RREADY=0.
- FIFO empty, dac_valid=0, dac_data=0.
- irq=0, done=0, rd_buf_index=0, read_count=0, fifo_underflow=0, rd_error=0.
- Internal addr, remain and burst registers to 0.
REQ-032 Release of ARESETN is synchronized internally. The first FSM transition occurs no earlier than the second ACLK edge after deassertion.

Verification
REQ-033 rd_addr_0=0x1000_0000, data_len=2048, dac_ready=1, go=1 -> two bursts: ARADDR 0x1000_0000 with ARLEN 127, then 0x1000_0400 with ARLEN 127. Then done=1, irq=1, rd_buf_index=0, read_count=1. dac_data sequence equals the memory contents in order.
REQ-034 data_len=1096 -> bursts of ARLEN 127 then ARLEN 8; the second ARADDR is base+0x400.
REQ-035 dac_ready=0 with FIFO_DEPTH=1024 -> exactly 8 bursts of 128 beats are issued, then the FSM holds in BURST_WAIT. After 128 pops, the next AR is issued.
REQ-036 Deassert go on beat 50 of a 128-beat burst -> RREADY stays 1 until RLAST, beats 50..127 are not stored, FSM ends in IDLE, dac_valid=0, irq=0.
REQ-037 Slave returns RRESP=2'b10 on one beat -> rd_error=1 and irq=1. An int_clr pulse clears both the next cycle.
REQ-038 Stall the slave (RVALID=0) so the FIFO empties while dac_ready=1 -> fifo_underflow=1 and irq=1.
REQ-039 Assert ARESETN=0 mid-burst -> all outputs reach their reset values without waiting for an ACLK edge.
